// File: rtl/store_sequencer.sv
// Store sequencer: queues byte/half/word stores and emits word-aligned masked write beats.
// Define STORE_SEQ_MISALIGN_SPLIT_EN to split word-crossing stores into two beats.
module store_sequencer #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ready,
    output logic        busy,
    output logic        misalign_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

`ifdef STORE_SEQ_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BEAT0 = 2'd1;
    localparam logic [1:0] BEAT1 = 2'd2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } req_t;

    req_t          fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          rdy_q;
    logic          full, empty, push, pop;

    logic [1:0]    state, state_nx;
    logic [29:0]   w_addr;
    logic [7:0]    w_m8;
    logic [63:0]   w_d64;
    logic          err_q;

    req_t          head;
    logic [3:0]    base;
    logic [31:0]   dsel;
    logic [7:0]    m8;
    logic [63:0]   d64;
    logic          h_bad;
    logic          beat_done;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    // rdy_q holds req_ready low through reset and for the cycle it is released
    assign req_ready = rdy_q && !full;
    assign push      = req_valid && req_ready;
    assign head      = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{addr: req_addr, data: req_data, size: req_size};
    end

    // Lane placement of the FIFO head, evaluated at pop time
    always_comb begin
        base = 4'b0000;
        dsel = 32'h0;
        case (head.size)
            2'b00: begin base = 4'b0001; dsel = {24'h0, head.data[7:0]};  end
            2'b01: begin base = 4'b0011; dsel = {16'h0, head.data[15:0]}; end
            2'b10: begin base = 4'b1111; dsel = head.data;                end
            default: ;
        endcase
        m8    = {4'b0000, base} << head.addr[1:0];
        d64   = {32'h0, dsel} << {head.addr[1:0], 3'b000};
        h_bad = (head.size == 2'b11) || (!SPLIT_EN && (m8[7:4] != 4'b0000));
    end

    assign beat_done = mem_wen && mem_ready;

    always_comb begin
        pop      = 1'b0;
        state_nx = state;
        case (state)
            IDLE:  if (!empty) pop = 1'b1;
            BEAT0: if (beat_done) begin
                       if (w_m8[7:4] != 4'b0000) state_nx = BEAT1;
                       else if (!empty)          pop = 1'b1;
                       else                      state_nx = IDLE;
                   end
            BEAT1: if (beat_done) begin
                       if (!empty) pop = 1'b1;
                       else        state_nx = IDLE;
                   end
            default: state_nx = IDLE;
        endcase
        // discarded entries park in IDLE so the next one is popped a cycle later
        if (pop) state_nx = h_bad ? IDLE : BEAT0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            w_addr <= '0;
            w_m8   <= '0;
            w_d64  <= '0;
            err_q  <= 1'b0;
            rdy_q  <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nx;
            err_q <= pop && h_bad;
            rdy_q <= 1'b1;
            if (pop && !h_bad) begin
                w_addr <= head.addr[31:2];
                w_m8   <= m8;
                w_d64  <= d64;
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_wen   = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wmask = 4'h0;
        case (state)
            BEAT0: begin
                mem_wen   = 1'b1;
                mem_addr  = {w_addr, 2'b00};
                mem_wdata = w_d64[31:0];
                mem_wmask = w_m8[3:0];
            end
            BEAT1: begin
                mem_wen   = 1'b1;
                mem_addr  = {w_addr + 30'd1, 2'b00};
                mem_wdata = w_d64[63:32];
                mem_wmask = w_m8[7:4];
            end
            default: ;
        endcase
    end

    assign busy         = !empty || (state != IDLE);
    assign misalign_err = err_q;

endmodule

// File: tb/tb_store_sequencer.sv
// Bench for store_sequencer: directed vector table, hand-written corner sequences,
// and random traffic scored against a byte-level model.
module tb_store_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_size = '0;
    logic        mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ready = 1'b0;
    logic        busy, misalign_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    store_sequencer #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ready(mem_ready), .busy(busy), .misalign_err(misalign_err)
    );

    typedef struct {
        bit          is_err;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } ev_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  s;
        int          nev;
        ev_t         e0;
        ev_t         e1;
    } vec_t;

    ev_t  obs_q[$];
    ev_t  exp_q[$];
    vec_t tbl[11];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic ev_t bt(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        ev_t e;
        e.is_err = 1'b0; e.addr = a; e.mask = m; e.data = d;
        return e;
    endfunction

    function automatic ev_t er();
        ev_t e;
        e.is_err = 1'b1; e.addr = '0; e.mask = '0; e.data = '0;
        return e;
    endfunction

    // Byte-by-byte placement: each byte lands in the word holding its own address.
    function automatic void model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        ev_t b0, b1;
        logic [31:0] wa0, ba;
        bit two;
        two = 1'b0;
        if (s == 2'b11) begin
            exp_q.push_back(er());
            return;
        end
        wa0 = a & 32'hFFFF_FFFC;
        b0 = bt(wa0, 4'h0, 32'h0);
        b1 = bt(wa0 + 32'd4, 4'h0, 32'h0);
        for (int i = 0; i < (1 << s); i++) begin
            ba = a + 32'(i);
            if ((ba & 32'hFFFF_FFFC) == wa0) begin
                b0.mask[ba[1:0]] = 1'b1;
                b0.data[8*ba[1:0] +: 8] = d[8*i +: 8];
            end else begin
                two = 1'b1;
                b1.mask[ba[1:0]] = 1'b1;
                b1.data[8*ba[1:0] +: 8] = d[8*i +: 8];
            end
        end
`ifdef STORE_SEQ_MISALIGN_SPLIT_EN
        exp_q.push_back(b0);
        if (two) exp_q.push_back(b1);
`else
        if (two) exp_q.push_back(er());
        else     exp_q.push_back(b0);
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_wen && mem_ready) obs_q.push_back(bt(mem_addr, mem_wmask, mem_wdata));
            if (misalign_err)         obs_q.push_back(er());
        end
    end

    // A stalled beat must present the same address/mask/data next cycle
    logic        pst = 1'b0;
    logic [31:0] pa, pd;
    logic [3:0]  pm;
    always @(negedge clk) begin
        if (rst) pst <= 1'b0;
        else begin
            if (pst) begin
                check32("stall wen",   mem_wen,   1);
                check32("stall addr",  mem_addr,  pa);
                check32("stall mask",  mem_wmask, pm);
                check32("stall wdata", mem_wdata, pd);
            end
            pst <= mem_wen && !mem_ready;
            pa  <= mem_addr;
            pm  <= mem_wmask;
            pd  <= mem_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        int n;
        n = 0;
        req_addr = a; req_data = d; req_size = s; req_valid = 1'b1;
        while (!req_ready && n < 50) begin tick(); n++; end
        if (!req_ready) begin
            vectors++; miscompares++;
            $display("FAIL send timeout: req_ready stayed 0 for addr %h", a);
        end else tick();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy && n < 200) begin tick(); n++; end
        check32("drain busy", busy, 0);
        tick();
        tick();
    endtask

    task automatic cmp_q(input string tag);
        check32({tag, " count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check32($sformatf("%s[%0d] kind", tag, i), obs_q[i].is_err, exp_q[i].is_err);
            if (!exp_q[i].is_err) begin
                check32($sformatf("%s[%0d] addr", tag, i), obs_q[i].addr, exp_q[i].addr);
                check32($sformatf("%s[%0d] mask", tag, i), obs_q[i].mask, exp_q[i].mask);
                check32($sformatf("%s[%0d] data", tag, i), obs_q[i].data, exp_q[i].data);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{32'h0000_0100, 32'hDEAD_BEEF, 2'd2, 1, bt(32'h100, 4'hF, 32'hDEAD_BEEF), er()};
        tbl[1]  = '{32'h0000_0103, 32'h0000_00AB, 2'd0, 1, bt(32'h100, 4'h8, 32'hAB00_0000), er()};
        tbl[4]  = '{32'h0000_0201, 32'hFFFF_A5C3, 2'd0, 1, bt(32'h200, 4'h2, 32'h0000_C300), er()};
        tbl[5]  = '{32'h0000_0302, 32'h1234_CAFE, 2'd1, 1, bt(32'h300, 4'hC, 32'hCAFE_0000), er()};
        tbl[6]  = '{32'h0000_0400, 32'h1234_5678, 2'd3, 1, er(), er()};
        tbl[8]  = '{32'h0000_0001, 32'hABCD_EF01, 2'd3, 1, er(), er()};
        tbl[9]  = '{32'h0000_0007, 32'h0000_0099, 2'd0, 1, bt(32'h4, 4'h8, 32'h9900_0000), er()};
`ifdef STORE_SEQ_MISALIGN_SPLIT_EN
        tbl[2]  = '{32'h0000_0102, 32'h1122_3344, 2'd2, 2,
                    bt(32'h100, 4'hC, 32'h3344_0000), bt(32'h104, 4'h3, 32'h0000_1122)};
        tbl[3]  = '{32'hFFFF_FFFF, 32'h0000_BEEF, 2'd1, 2,
                    bt(32'hFFFF_FFFC, 4'h8, 32'hEF00_0000), bt(32'h0, 4'h1, 32'h0000_00BE)};
        tbl[7]  = '{32'h0000_0103, 32'h0000_5566, 2'd1, 2,
                    bt(32'h100, 4'h8, 32'h6600_0000), bt(32'h104, 4'h1, 32'h0000_0055)};
        tbl[10] = '{32'hFFFF_FFFD, 32'hCAFE_F00D, 2'd2, 2,
                    bt(32'hFFFF_FFFC, 4'hE, 32'hFEF0_0D00), bt(32'h0, 4'h1, 32'h0000_00CA)};
`else
        tbl[2]  = '{32'h0000_0102, 32'h1122_3344, 2'd2, 1, er(), er()};
        tbl[3]  = '{32'hFFFF_FFFF, 32'h0000_BEEF, 2'd1, 1, er(), er()};
        tbl[7]  = '{32'h0000_0103, 32'h0000_5566, 2'd1, 1, er(), er()};
        tbl[10] = '{32'hFFFF_FFFD, 32'hCAFE_F00D, 2'd2, 1, er(), er()};
`endif

        // reset state
        #1 rst = 1'b1;
        tick(); tick();
        check32("rst mem_wen", mem_wen, 0);
        check32("rst mem_addr", mem_addr, 0);
        check32("rst mem_wdata", mem_wdata, 0);
        check32("rst mem_wmask", mem_wmask, 0);
        check32("rst misalign_err", misalign_err, 0);
        check32("rst busy", busy, 0);
        check32("rst req_ready", req_ready, 0);
        rst = 1'b0;
        tick();
        check32("req_ready after rst", req_ready, 1);

        // minimum latency: accepted at edge N, beat visible after edge N+1
        obs_q.delete(); exp_q.delete();
        mem_ready = 1'b0;
        send(32'h100, 32'hDEAD_BEEF, 2'd2);
        check32("latency wen after N", mem_wen, 0);
        check32("latency busy after N", busy, 1);
        tick();
        check32("latency wen after N+1", mem_wen, 1);
        mem_ready = 1'b1;
        model(32'h100, 32'hDEAD_BEEF, 2'd2);
        drain();
        cmp_q("latency");

        // directed vector table
        foreach (tbl[k]) begin
            obs_q.delete(); exp_q.delete();
            mem_ready = 1'b1;
            send(tbl[k].a, tbl[k].d, tbl[k].s);
            drain();
            exp_q.push_back(tbl[k].e0);
            if (tbl[k].nev > 1) exp_q.push_back(tbl[k].e1);
            cmp_q($sformatf("tbl%0d", k));
        end

        // backpressure: three requests fill the working register and both FIFO slots
        obs_q.delete(); exp_q.delete();
        mem_ready = 1'b0;
        send(32'h500, 32'h0101_0101, 2'd2); model(32'h500, 32'h0101_0101, 2'd2);
        send(32'h504, 32'h0202_0202, 2'd2); model(32'h504, 32'h0202_0202, 2'd2);
        send(32'h509, 32'h0000_0033, 2'd0); model(32'h509, 32'h0000_0033, 2'd0);
        check32("bp req_ready full", req_ready, 0);
        check32("bp wen stalled", mem_wen, 1);
        check32("bp addr stalled", mem_addr, 32'h500);
        repeat (4) tick();
        check32("bp req_ready still full", req_ready, 0);
        check32("bp addr held", mem_addr, 32'h500);
        mem_ready = 1'b1;
        drain();
        cmp_q("bp");

        // reset in the middle of a split store
        obs_q.delete();
        mem_ready = 1'b0;
        send(32'h102, 32'h1122_3344, 2'd2);
        tick();
        rst = 1'b1;
        #1;
        check32("midrst mem_wen", mem_wen, 0);
        check32("midrst mem_addr", mem_addr, 0);
        check32("midrst mem_wdata", mem_wdata, 0);
        check32("midrst mem_wmask", mem_wmask, 0);
        check32("midrst busy", busy, 0);
        check32("midrst misalign_err", misalign_err, 0);
        tick();
        rst = 1'b0;
        mem_ready = 1'b1;
        tick();
        check32("midrst req_ready", req_ready, 1);
        repeat (5) tick();
        check32("midrst no beats", obs_q.size(), 0);

        // random traffic against the byte-level model
        obs_q.delete(); exp_q.delete();
        for (int c = 0; c < 3000; c++) begin
            req_valid = ($urandom_range(0, 2) != 0);
            req_addr  = $urandom();
            if ($urandom_range(0, 7) == 0) req_addr = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            req_data  = $urandom();
            req_size  = 2'($urandom_range(0, 3));
            mem_ready = ($urandom_range(0, 3) != 0);
            if (req_valid && req_ready) model(req_addr, req_data, req_size);
            tick();
        end
        req_valid = 1'b0;
        mem_ready = 1'b1;
        drain();
        cmp_q("rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/store_sequencer.md
STORE_SEQUENCER -- requirements
Module: store_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, request-queue entries (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req_valid input 1 / req_ready output 1: store request handshake; a request is accepted on an edge where both are high.
REQ-005 SHALL have ports req_addr input 32 (byte address), req_data input 32 (store data, LSB-aligned), req_size input 2 (00 byte, 01 half, 10 word, 11 reserved).
REQ-006 SHALL have ports mem_wen output 1, mem_addr output 32 (word-aligned), mem_wdata output 32, mem_wmask output 4 (one bit per byte lane).
REQ-007 SHALL have port mem_ready input 1: a beat completes on an edge where mem_wen and mem_ready are both high.
REQ-008 SHALL have ports busy output 1 (queue non-empty or FSM not IDLE) and misalign_err output 1 (one-cycle pulse).

Function
REQ-009 SHALL buffer accepted requests in a DEPTH-entry FIFO; req_ready = !full; no bypass, no enqueue when full.
REQ-010 SHALL run FSM states IDLE, BEAT0, BEAT1.
REQ-011 IDLE: if FIFO non-empty, pop head into working register, go BEAT0; else stay.
REQ-012 Lane math: off = addr[1:0]; base mask 0001/0011/1111 for byte/half/word; m8 = base << off (8 bits); d64 = {32'h0,data masked to size} << 8*off.
REQ-013 BEAT0 SHALL drive mem_addr = {addr[31:2],2'b00}, mem_wmask = m8[3:0], mem_wdata = d64[31:0]; unused lanes zero.
REQ-014 BEAT1 SHALL drive mem_addr = BEAT0 address + 4 (mod 2^32; 0xFFFFFFFC wraps to 0x00000000), mem_wmask = m8[7:4], mem_wdata = d64[63:32].
REQ-015 On beat completion in BEAT0: go BEAT1 if m8[7:4] != 0; else pop next entry and stay BEAT0 if FIFO non-empty, else IDLE.
REQ-016 On beat completion in BEAT1: pop next entry and go BEAT0 if FIFO non-empty, else IDLE.
REQ-017 mem_wen SHALL be high exactly in BEAT0/BEAT1; mem_addr, mem_wdata and mem_wmask SHALL hold stable while mem_wen=1 and mem_ready=0.
REQ-018 Minimum latency: request accepted at edge N into an empty, IDLE block SHALL give mem_wen=1 after edge N+1.
REQ-019 An entry with req_size=11 SHALL produce no beat; it is discarded at pop and misalign_err pulses for the cycle after the pop.
REQ-020 Enqueue and pop on the same edge SHALL both take effect; FIFO pointers wrap modulo DEPTH.
REQ-021 busy SHALL fall only in the cycle after the last beat completes with the FIFO empty.

Reset
REQ-022 While rst=1: FIFO empty, state IDLE, mem_wen=0, mem_addr=0, mem_wdata=0, mem_wmask=0, misalign_err=0, busy=0, req_ready=0.
REQ-023 After rst deasserts, req_ready SHALL be 1 from the next cycle.
REQ-024 Reset mid-operation SHALL abandon any pending beat (no BEAT1 after reset) and discard queued entries.

Configuration
REQ-025 With STORE_SEQ_MISALIGN_SPLIT_EN defined, entries with m8[7:4] != 0 SHALL be split into BEAT0 + BEAT1, and misalign_err SHALL pulse only for size 11.
REQ-026 Without STORE_SEQ_MISALIGN_SPLIT_EN, entries with m8[7:4] != 0 SHALL produce no beat; they are discarded at pop and misalign_err pulses once per entry; BEAT1 is never entered.

Verification
REQ-027 Word store: addr 0x100, data 0xDEADBEEF, size 10, mem_ready=1 -> one beat: addr 0x100, mask 1111, wdata 0xDEADBEEF.
REQ-028 Byte store: addr 0x103, data 0x000000AB -> one beat: addr 0x100, mask 1000, wdata 0xAB000000.
REQ-029 Misaligned word, addr 0x102, data 0x11223344, macro on -> beats (0x100, 1100, 0x33440000) then (0x104, 0011, 0x00001122); macro off -> no mem_wen, one misalign_err pulse.
REQ-030 Wrap split, half store: addr 0xFFFFFFFF, data 0xBEEF, macro on -> beats (0xFFFFFFFC, 1000, 0xEF000000) then (0x00000000, 0001, 0x000000BE).
REQ-031 Backpressure: mem_ready=0 for 4 cycles, 3 requests offered with DEPTH=2 -> req_ready drops when the FIFO is full; outputs stable while stalled; all requests written in order after mem_ready=1.
REQ-032 Reset mid-split: rst pulsed while in BEAT0 of a split store -> no BEAT1 beat; all outputs 0; busy=0; req_ready=1 one cycle after rst falls.
